hub75_scan_ctrl: RTL and testbench

- Drives a chained HUB75 LED panel string: 512 columns (8 x 64), 1/32 scan with two half-panel data lines.
- Generates read address and bit-plane select into the frame-buffer / test-pattern memory and consumes its r0/g0/b0/r1/g1/b1 outputs.
- Serialises that data onto the panel with HUB75 clock, latch, output enable and row address.
- Uses binary-code modulation across bit planes 2..7 (RGB666).

---
 rtl/hub75_pkg.sv | 40 ++++
 rtl/hub75_oe_timer.sv | 73 +++++++
 rtl/hub75_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared definitions for the HUB75 scan controller.
//               - Scan state enumeration.
//               - Bit-plane range used for binary-code modulation (RGB666).
//               - Memory address field widths and the rd_addr packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SHIFT      = 3'd1,
    ST_DRAIN      = 3'd2,
    ST_BLANK_PRE  = 3'd3,
    ST_LATCH      = 3'd4,
    ST_BLANK_POST = 3'd5,
    ST_DISPLAY    = 3'd6
  } state_t;

  localparam int PLANE_MIN   = 2;
  localparam int PLANE_MAX   = 7;
  localparam int PLANE_W     = 3;

  // rd_addr is always {row[4:0], col[8:0]}, independent of the configured
  // COLS/ROWS; narrower counters are zero-extended into these fields.
  localparam int ROW_FIELD_W = 5;
  localparam int COL_FIELD_W = 9;
  localparam int ADDR_W      = ROW_FIELD_W + COL_FIELD_W;

  function automatic logic [ADDR_W-1:0] pack_rd_addr(
    input logic [ROW_FIELD_W-1:0] row,
    input logic [COL_FIELD_W-1:0] col
  );
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_oe_timer.sv
`default_nettype none
// ============================================================================
// Module      : hub75_oe_timer
// Description : Loadable down-counter timing the BLANK and DISPLAY windows.
//               'done' is high in the last cycle of a loaded window.
//               'lit_next' tells whether the cycle after this edge lies in
//               the lit part of the window, so the caller can register OE.
//               Optional macro HUB75_BRIGHTNESS_EN adds brightness scaling:
//               the lit part becomes the first (len*brightness)>>8 cycles.
// Ports       : clk, reset            clock, async active-high reset
//               load, load_val        start a new window of load_val cycles
//               scale, brightness     (HUB75_BRIGHTNESS_EN only)
//               done                  last cycle of current window
//               lit_next              next cycle is inside the lit portion
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_oe_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic             scale,
  input  logic [7:0]       brightness,
`endif
  output logic             done,
  output logic             lit_next
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] thr_nxt;
  logic [CNT_W-1:0] lit_len;

`ifdef HUB75_BRIGHTNESS_EN
  logic [CNT_W+7:0] prod;
  assign prod    = (CNT_W+8)'(load_val) * (CNT_W+8)'(brightness);
  assign lit_len = scale ? CNT_W'(prod >> 8) : load_val;
`else
  assign lit_len = load_val;
`endif

  // Counter runs load_val..1; the window is lit while cnt is above thr,
  // i.e. for the first lit_len cycles.
  always_comb begin
    cnt_nxt = cnt;
    thr_nxt = thr;
    if (load) begin
      cnt_nxt = load_val;
      thr_nxt = load_val - lit_len;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  assign lit_next = (cnt_nxt > thr_nxt);
  assign done     = (cnt <= CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      thr <= '0;
    end else begin
      cnt <= cnt_nxt;
      thr <= thr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_ctrl
// Description : HUB75 panel-chain scan controller, 1/ROWS scan, two half-panel
//               data lines, binary-code modulation over bit planes 2..7.
//               Per plane: SHIFT pixels, DRAIN the pipeline, blank, latch and
//               change row, blank, then DISPLAY for BASE_CYCLES<<(plane-2).
//               Optional macro HUB75_BRIGHTNESS_EN adds input brightness[7:0]
//               which shortens the lit part of each DISPLAY window.
// Ports       : clk, reset, enable            clock, async reset, run
//               rd_addr, rd_bit_plane         memory read address / plane
//               r0,g0,b0,r1,g1,b1             memory pixel bits
//               hub_r0..hub_b1                registered panel data
//               hub_clk, hub_lat, hub_oe_n    panel shift clock/latch/OE_n
//               hub_row                       panel row address A..E
//               frame_start                   pulse on first SHIFT of row0/p2
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS         = 512,
  parameter int ROWS         = 32,
  parameter int RD_LATENCY   = 2,
  parameter int BASE_CYCLES  = 64,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]             brightness,
`endif
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [PLANE_W-1:0]     rd_bit_plane,
  input  logic                   r0,
  input  logic                   g0,
  input  logic                   b0,
  input  logic                   r1,
  input  logic                   g1,
  input  logic                   b1,
  output logic                   hub_r0,
  output logic                   hub_g0,
  output logic                   hub_b0,
  output logic                   hub_r1,
  output logic                   hub_g1,
  output logic                   hub_b1,
  output logic                   hub_clk,
  output logic                   hub_lat,
  output logic                   hub_oe_n,
  output logic [ROW_FIELD_W-1:0] hub_row,
  output logic                   frame_start
);

  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int T_W     = $clog2(2*COLS + RD_LATENCY + 2) + 1;
  localparam int DUR_MAX = BASE_CYCLES << (PLANE_MAX - PLANE_MIN);
  localparam int CNT_MAX = (DUR_MAX > BLANK_CYCLES) ? DUR_MAX : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PLANE_W-1:0] P_MIN        = PLANE_W'(PLANE_MIN);
  localparam logic [PLANE_W-1:0] P_MAX        = PLANE_W'(PLANE_MAX);
  localparam logic [ROW_W-1:0]   ROW_LAST     = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(COLS - 1);
  localparam logic [T_W-1:0]     T_SHIFT_LAST = T_W'(2*COLS - 1);
  localparam logic [T_W-1:0]     T_DRAIN_LAST = T_W'(2*COLS + RD_LATENCY);
  localparam logic [T_W-1:0]     T_LAT        = T_W'(RD_LATENCY);
  localparam logic [T_W-1:0]     T_COLS       = T_W'(COLS);

  state_t             state;
  state_t             next_state;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   adv_row;
  logic [ROW_W-1:0]   seq_row;
  logic [PLANE_W-1:0] plane;
  logic [PLANE_W-1:0] adv_plane;
  logic [PLANE_W-1:0] seq_plane;
  logic [COL_W-1:0]   col;
  logic [T_W-1:0]     t;
  logic [T_W-1:0]     t_rel;
  logic               cap;
  logic               cap_q;
  logic               start_shift;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_val;
  logic               timer_done;
  logic               lit_next;

  assign rd_addr      = pack_rd_addr(ROW_FIELD_W'(row), COL_FIELD_W'(col));
  assign rd_bit_plane = plane;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (enable)                  next_state = ST_SHIFT;
      ST_SHIFT:      if (t == T_SHIFT_LAST)       next_state = ST_DRAIN;
      ST_DRAIN:      if (t == T_DRAIN_LAST)       next_state = ST_BLANK_PRE;
      ST_BLANK_PRE:  if (timer_done)              next_state = ST_LATCH;
      ST_LATCH:                                   next_state = ST_BLANK_POST;
      ST_BLANK_POST: if (timer_done)              next_state = ST_DISPLAY;
      // enable is only sampled here so a stop always finishes the plane.
      ST_DISPLAY:    if (timer_done)              next_state = enable ? ST_SHIFT : ST_IDLE;
      default:                                    next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencing helpers
  // --------------------------------------------------------------------------
  always_comb begin
    adv_plane = plane + PLANE_W'(1);
    adv_row   = row;
    if (plane == P_MAX) begin
      adv_plane = P_MIN;
      adv_row   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end
    // A start from IDLE always begins a fresh frame.
    seq_row   = adv_row;
    seq_plane = adv_plane;
    if (state == ST_IDLE) begin
      seq_row   = '0;
      seq_plane = P_MIN;
    end
  end

  assign start_shift = (next_state == ST_SHIFT) && (state != ST_SHIFT);

  // Pixel i is addressed at t=2i,2i+1; its data is valid from t=2i+RD_LATENCY
  // and is sampled at the end of that cycle. hub_clk rises one cycle after
  // new data appears on the pins, so data is stable around the rising edge.
  assign t_rel = t - T_LAT;
  assign cap   = ((state == ST_SHIFT) || (state == ST_DRAIN)) &&
                 (t >= T_LAT) && !t_rel[0] && ((t_rel >> 1) < T_COLS);

  assign timer_load = (next_state != state) &&
                      (next_state inside {ST_BLANK_PRE, ST_BLANK_POST, ST_DISPLAY});
  assign timer_val  = (next_state == ST_DISPLAY) ?
                      (CNT_W'(BASE_CYCLES) << (plane - P_MIN)) :
                      CNT_W'(BLANK_CYCLES);

  hub75_oe_timer #(
    .CNT_W      (CNT_W)
  ) u_oe_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_val   (timer_val),
`ifdef HUB75_BRIGHTNESS_EN
    .scale      (next_state == ST_DISPLAY),
    .brightness (brightness),
`endif
    .done       (timer_done),
    .lit_next   (lit_next)
  );

  // --------------------------------------------------------------------------
  // Datapath and registered panel outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row         <= '0;
      plane       <= P_MIN;
      col         <= '0;
      t           <= '0;
      cap_q       <= 1'b0;
      hub_r0      <= 1'b0;
      hub_g0      <= 1'b0;
      hub_b0      <= 1'b0;
      hub_r1      <= 1'b0;
      hub_g1      <= 1'b0;
      hub_b1      <= 1'b0;
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_row     <= '0;
      frame_start <= 1'b0;
    end else begin
      cap_q       <= cap;
      hub_clk     <= cap_q;
      hub_lat     <= (next_state == ST_LATCH);
      hub_oe_n    <= !((next_state == ST_DISPLAY) && lit_next);
      frame_start <= start_shift && (seq_row == '0) && (seq_plane == P_MIN);

      if (cap) begin
        hub_r0 <= r0;
        hub_g0 <= g0;
        hub_b0 <= b0;
        hub_r1 <= r1;
        hub_g1 <= g1;
        hub_b1 <= b1;
      end

      if ((next_state == ST_LATCH) && (state != ST_LATCH)) begin
        hub_row <= ROW_FIELD_W'(row);
      end

      if (start_shift) begin
        row   <= seq_row;
        plane <= seq_plane;
        col   <= '0;
        t     <= '0;
      end else if ((state == ST_SHIFT) || (state == ST_DRAIN)) begin
        t <= t + T_W'(1);
        // Column holds at the last pixel once the row has been issued.
        if ((state == ST_SHIFT) && t[0] && (col != COL_LAST)) begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_ctrl
// Description : Self-checking bench for hub75_scan_ctrl with a small panel
//               (COLS=4, ROWS=2, RD_LATENCY=2, BASE_CYCLES=4, BLANK_CYCLES=2)
//               and a two-cycle-latency pattern memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_ctrl;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int LAT   = 2;
  localparam int BASE  = 4;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'd128;
`endif
  logic [13:0] rd_addr;
  logic [2:0]  rd_bit_plane;
  logic        r0, g0, b0, r1, g1, b1;
  logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
  logic        hub_clk, hub_lat, hub_oe_n, frame_start;
  logic [4:0]  hub_row;

  always #5 clk = ~clk;

  hub75_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .RD_LATENCY(LAT),
    .BASE_CYCLES(BASE), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rd_addr(rd_addr), .rd_bit_plane(rd_bit_plane),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_row(hub_row), .frame_start(frame_start)
  );

  // Pattern depends on row, column and plane so every sampled value is unique.
  function automatic logic [5:0] pat(input int row, input int col, input int plane);
    return 6'((col*9 + row*17 + plane*3 + 1) & 63);
  endfunction

  function automatic int exp_lit(input int dur);
`ifdef HUB75_BRIGHTNESS_EN
    return (dur * 128) >> 8;
`else
    return dur;
`endif
  endfunction

  // Memory model: two register stages between address and data.
  logic [5:0] m1 = '0, m2 = '0;
  always @(posedge clk) begin
    m1 <= pat(int'(rd_addr[13:9]), int'(rd_addr[8:0]), int'(rd_bit_plane));
    m2 <= m1;
  end
  assign {r0, g0, b0, r1, g1, b1} = m2;

  // Observer
  int         cyc = 0;
  int         run = 0;
  int         rises_since = 0;
  int         oe_low_total = 0;
  logic       prev_clk = 1'b0;
  logic       oe_arr [8192];
  int         lat_cyc_q[$], lat_row_q[$], lat_rise_q[$], oe_run_q[$];
  int         fs_cyc_q[$], fs_addr_q[$], fs_plane_q[$];
  logic [5:0] rise_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc < 8192) oe_arr[cyc] = hub_oe_n;
    if (reset) begin
      run = 0;
      rises_since = 0;
    end else begin
      if (hub_clk && !prev_clk) begin
        rise_q.push_back({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1});
        rises_since = rises_since + 1;
      end
      if (hub_lat) begin
        lat_cyc_q.push_back(cyc);
        lat_row_q.push_back(int'(hub_row));
        lat_rise_q.push_back(rises_since);
        rises_since = 0;
      end
      if (!hub_oe_n) begin
        run = run + 1;
        oe_low_total = oe_low_total + 1;
      end else if (run != 0) begin
        oe_run_q.push_back(run);
        run = 0;
      end
      if (frame_start) begin
        fs_cyc_q.push_back(cyc);
        fs_addr_q.push_back(int'(rd_addr));
        fs_plane_q.push_back(int'(rd_bit_plane));
      end
    end
    prev_clk = hub_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int count_of(input int sel);
    case (sel)
      0:       return lat_row_q.size();
      1:       return fs_cyc_q.size();
      default: return rise_q.size();
    endcase
  endfunction

  task automatic wait_count(input int sel, input int n, input int budget, input string what);
    int k = 0;
    while (count_of(sel) < n && k < budget) begin
      tick();
      k++;
    end
    if (count_of(sel) < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: got %0d expected %0d", what, count_of(sel), n);
    end
  endtask

  typedef struct {
    int row;
    int plane;
    int dur;
  } vec_t;
  vec_t tab[12];

  task automatic check_plane(input int idx, input int row, input int plane);
    for (int j = 0; j < COLS; j++) begin
      check($sformatf("data_l%0d_c%0d", idx, j),
            int'(rise_q[idx*COLS + j]), int'(pat(row, j, plane)));
    end
  endtask

  initial begin
    for (int k = 0; k < 12; k++) begin
      tab[k].row   = k / 6;
      tab[k].plane = 2 + (k % 6);
      tab[k].dur   = BASE << (k % 6);
    end

    // Reset values
    tick(); tick();
    check("rst_rd_addr",   int'(rd_addr), 0);
    check("rst_plane",     int'(rd_bit_plane), 2);
    check("rst_hub_data",  int'({hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1}), 0);
    check("rst_hub_clk",   int'(hub_clk), 0);
    check("rst_hub_lat",   int'(hub_lat), 0);
    check("rst_hub_oe_n",  int'(hub_oe_n), 1);
    check("rst_hub_row",   int'(hub_row), 0);
    check("rst_frame",     int'(frame_start), 0);

    // Full scan of both rows and the first plane of the next frame
    reset  = 1'b0;
    enable = 1'b1;
    wait_count(0, 13, 3000, "full_scan");
    for (int k = 0; k < 12; k++) begin
      int c;
      int ok;
      c  = lat_cyc_q[k];
      ok = int'(oe_arr[c-2] & oe_arr[c-1] & oe_arr[c] & oe_arr[c+1] &
                oe_arr[c+2] & ~oe_arr[c+3]);
      check($sformatf("lat_row_%0d", k),   lat_row_q[k], tab[k].row);
      check($sformatf("lat_rises_%0d", k), lat_rise_q[k], COLS);
      check($sformatf("oe_len_%0d", k),    oe_run_q[k], exp_lit(tab[k].dur));
      check($sformatf("blank_%0d", k),     ok, 1);
      check_plane(k, tab[k].row, tab[k].plane);
    end
    check("row_wrap", lat_row_q[12], 0);
    check("frame_cnt", fs_cyc_q.size(), 2);
    begin
      int between = 0;
      foreach (lat_cyc_q[i])
        if (lat_cyc_q[i] > fs_cyc_q[0] && lat_cyc_q[i] < fs_cyc_q[1]) between++;
      check("lat_per_frame", between, 12);
    end
    check("fs0_addr",  fs_addr_q[0], 0);
    check("fs0_plane", fs_plane_q[0], 2);
    check("fs1_addr",  fs_addr_q[1], 0);
    check("fs1_plane", fs_plane_q[1], 2);

    // Drop enable in the middle of the row0/plane3 shift
    wait_count(2, 13*COLS + 1, 200, "shift_start");
    enable = 1'b0;
    repeat (300) tick();
    check("stop_lat_cnt",  lat_row_q.size(), 14);
    check("stop_lat_row",  lat_row_q[13], 0);
    check("stop_rises",    rise_q.size(), 14*COLS);
    check("stop_oe_cnt",   oe_run_q.size(), 14);
    check("stop_oe_len",   oe_run_q[13], exp_lit(8));
    check("stop_oe_n",     int'(hub_oe_n), 1);
    check("stop_no_frame", fs_cyc_q.size(), 2);
    check_plane(13, 0, 3);

    // Re-enable restarts at row 0 plane 2
    enable = 1'b1;
    wait_count(1, 3, 50, "reenable");
    check("re_fs_addr",  fs_addr_q[2], 0);
    check("re_fs_plane", fs_plane_q[2], 2);
    wait_count(0, 15, 200, "reenable_lat");
    check("re_lat_row", lat_row_q[14], 0);
    check_plane(14, 0, 2);

    // Reset in the middle of row-1 display
    wait_count(0, 21, 1500, "row1");
    check("row1_lat", lat_row_q[20], 1);
    begin
      int k = 0;
      while (hub_oe_n && k < 20) begin
        tick();
        k++;
      end
      check("display_reached", int'(hub_oe_n), 0);
    end
    reset = 1'b1;
    #1;
    check("ar_oe_n",    int'(hub_oe_n), 1);
    check("ar_lat",     int'(hub_lat), 0);
    check("ar_row",     int'(hub_row), 0);
    check("ar_plane",   int'(rd_bit_plane), 2);
    check("ar_rd_addr", int'(rd_addr), 0);
    tick(); tick();
    reset = 1'b0;
    wait_count(1, 4, 20, "post_reset");
    check("pr_fs_addr",  fs_addr_q[3], 0);
    check("pr_fs_plane", fs_plane_q[3], 2);

`ifdef HUB75_BRIGHTNESS_EN
    // brightness=0 keeps the panel dark once a fresh window is loaded
    brightness = 8'd0;
    begin
      int n0;
      int low0;
      n0 = lat_row_q.size();
      wait_count(0, n0 + 1, 400, "bright0_a");
      low0 = oe_low_total;
      wait_count(0, n0 + 3, 800, "bright0_b");
      check("bright0_dark", oe_low_total - low0, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
